// File: rtl/mem_wb_stage.sv
// MEM-stage access controller and MEM/WB pipeline register for a variable-latency data memory.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int REG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              em_valid,
  input  logic              em_reg_write,
  input  logic              em_mem_read,
  input  logic              em_mem_write,
  input  logic [REG_W-1:0]  em_reg_rd,
  input  logic [DATA_W-1:0] em_alu_out,
  input  logic [DATA_W-1:0] em_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_stall,
  output logic              mem_err,
  output logic              mw_valid,
  output logic              mw_reg_write,
  output logic              mw_mem_read,
  output logic [REG_W-1:0]  mw_reg_rd,
  output logic [DATA_W-1:0] mw_wb_data
);

  // state  | meaning
  // S_IDLE | no access outstanding; requests issue straight from EX/MEM
  // S_WAIT | access outstanding; request driven from latched copy
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              w_access;
  logic              w_em_we;
  logic [ADDR_W-1:0] w_em_addr;
  logic              w_latch;
  logic              w_complete;
  logic              w_timeout;
  logic              w_to_hit;
  logic              w_load;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;

  logic              r_mw_valid;
  logic              r_mw_reg_write;
  logic              r_mw_mem_read;
  logic [REG_W-1:0]  r_mw_reg_rd;
  logic [DATA_W-1:0] r_mw_wb_data;

  assign w_access  = em_valid & (em_mem_read | em_mem_write);
  // A read wins when both read and write are flagged.
  assign w_em_we   = em_mem_write & ~em_mem_read;
  assign w_em_addr = ADDR_W'(em_alu_out);

`ifdef MEM_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_err;

  assign w_to_hit = (r_state == S_WAIT) && (r_cnt == 16'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_latch)
        r_cnt <= '0;
      else if ((r_state == S_WAIT) && !mem_ready && !w_to_hit)
        r_cnt <= r_cnt + 16'd1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign mem_err = r_err;
`else
  logic w_unused_timeout;

  assign w_to_hit         = 1'b0;
  assign mem_err          = 1'b0;
  assign w_unused_timeout = ^(32'(TIMEOUT_CYC));
`endif

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = w_em_addr;
    mem_wdata   = em_store_data;
    mem_stall   = 1'b0;
    w_latch     = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          mem_req = 1'b1;
          mem_we  = w_em_we;
          if (mem_ready) begin
            w_complete = 1'b1;
          end else begin
            mem_stall   = 1'b1;
            w_latch     = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        mem_we    = r_we;
        if (w_to_hit) begin
          // Abort: drop the request and release upstream this cycle.
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            mem_stall = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_addr  <= w_em_addr;
        r_wdata <= em_store_data;
        r_we    <= w_em_we;
      end
    end
  end

  assign w_load = (em_valid & ~w_access) | w_complete | w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mw_valid     <= 1'b0;
      r_mw_reg_write <= 1'b0;
      r_mw_mem_read  <= 1'b0;
      r_mw_reg_rd    <= '0;
      r_mw_wb_data   <= '0;
    end else if (w_load) begin
      r_mw_valid     <= 1'b1;
      r_mw_reg_write <= em_reg_write & ~w_timeout;
      r_mw_mem_read  <= em_mem_read & ~w_timeout;
      r_mw_reg_rd    <= em_reg_rd;
      r_mw_wb_data   <= (em_mem_read & ~w_timeout) ? mem_rdata : em_alu_out;
    end else begin
      // Bubble: control cleared, rd and data held.
      r_mw_valid     <= 1'b0;
      r_mw_reg_write <= 1'b0;
      r_mw_mem_read  <= 1'b0;
    end
  end

  assign mw_valid     = r_mw_valid;
  assign mw_reg_write = r_mw_reg_write;
  assign mw_mem_read  = r_mw_mem_read;
  assign mw_reg_rd    = r_mw_reg_rd;
  assign mw_wb_data   = r_mw_wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: hit, ALU, waited load/store, reset mid-wait, timeout.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        em_valid, em_reg_write, em_mem_read, em_mem_write;
  logic [3:0]  em_reg_rd;
  logic [15:0] em_alu_out, em_store_data;
  logic        mem_req, mem_we, mem_stall, mem_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        mw_valid, mw_reg_write, mw_mem_read;
  logic [3:0]  mw_reg_rd;
  logic [15:0] mw_wb_data;

  int errors = 0;
  int checks = 0;

  mem_wb_stage #(.DATA_W(16), .ADDR_W(16), .REG_W(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .em_valid(em_valid), .em_reg_write(em_reg_write),
    .em_mem_read(em_mem_read), .em_mem_write(em_mem_write),
    .em_reg_rd(em_reg_rd), .em_alu_out(em_alu_out), .em_store_data(em_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
    .mem_err(mem_err), .mw_valid(mw_valid), .mw_reg_write(mw_reg_write),
    .mw_mem_read(mw_mem_read), .mw_reg_rd(mw_reg_rd), .mw_wb_data(mw_wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic [3:0] rd, input logic [15:0] alu, input logic [15:0] sd);
    em_valid      = v;
    em_reg_write  = rw;
    em_mem_read   = mr;
    em_mem_write  = mw;
    em_reg_rd     = rd;
    em_alu_out    = alu;
    em_store_data = sd;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 16'h0000;
    drive(1, 1, 1, 0, 4'd1, 16'h0010, 16'h0000);
    #2;
    chk("rst_req",      32'(mem_req), 0);
    chk("rst_stall",    32'(mem_stall), 0);
    chk("rst_mw_valid", 32'(mw_valid), 0);
    chk("rst_mw_rd",    32'(mw_reg_rd), 0);
    chk("rst_mw_data",  32'(mw_wb_data), 0);
    chk("rst_err",      32'(mem_err), 0);
    tick();
    drive(0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000);
    rst = 1'b0;
    tick();

    // 1: zero-wait load
    drive(1, 1, 1, 0, 4'd5, 16'h0040, 16'h0000);
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    chk("t1_req",   32'(mem_req), 1);
    chk("t1_we",    32'(mem_we), 0);
    chk("t1_addr",  32'(mem_addr), 32'h0040);
    chk("t1_stall", 32'(mem_stall), 0);
    tick();
    chk("t1_valid", 32'(mw_valid), 1);
    chk("t1_rw",    32'(mw_reg_write), 1);
    chk("t1_mr",    32'(mw_mem_read), 1);
    chk("t1_rd",    32'(mw_reg_rd), 5);
    chk("t1_data",  32'(mw_wb_data), 32'hBEEF);

    // 2: ALU op
    drive(1, 1, 0, 0, 4'd3, 16'h1234, 16'h0000);
    mem_ready = 1'b0; mem_rdata = 16'hFFFF;
    #1;
    chk("t2_req",   32'(mem_req), 0);
    chk("t2_stall", 32'(mem_stall), 0);
    tick();
    chk("t2_data",  32'(mw_wb_data), 32'h1234);
    chk("t2_mr",    32'(mw_mem_read), 0);
    chk("t2_rd",    32'(mw_reg_rd), 3);

    // 3: load with 3 wait cycles; EX/MEM address disturbed to prove the latch
    drive(1, 1, 1, 0, 4'd7, 16'h0100, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall", 32'(mem_stall), 1);
      chk("t3_req",   32'(mem_req), 1);
      chk("t3_addr",  32'(mem_addr), 32'h0100);
      tick();
      chk("t3_bubble", 32'(mw_valid), 0);
      chk("t3_rd_hold",   32'(mw_reg_rd), 3);
      chk("t3_data_hold", 32'(mw_wb_data), 32'h1234);
      em_alu_out = 16'hDEAD;
    end
    mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    #1;
    chk("t3_stall_done", 32'(mem_stall), 0);
    chk("t3_addr_done",  32'(mem_addr), 32'h0100);
    tick();
    chk("t3_valid", 32'(mw_valid), 1);
    chk("t3_data",  32'(mw_wb_data), 32'h5A5A);
    chk("t3_rd",    32'(mw_reg_rd), 7);

    // em_valid=0 bubble
    drive(0, 1, 0, 0, 4'd8, 16'h9999, 16'h0000);
    mem_ready = 1'b0;
    tick();
    chk("bub_valid", 32'(mw_valid), 0);
    chk("bub_rw",    32'(mw_reg_write), 0);
    chk("bub_data",  32'(mw_wb_data), 32'h5A5A);

    // 4: store with 2 wait cycles
    drive(1, 0, 0, 1, 4'd0, 16'h0020, 16'h00AA);
    #1;
    chk("t4_we",    32'(mem_we), 1);
    chk("t4_wdata", 32'(mem_wdata), 32'h00AA);
    chk("t4_stall", 32'(mem_stall), 1);
    tick();
    em_store_data = 16'h0000;
    #1;
    chk("t4_we_w",    32'(mem_we), 1);
    chk("t4_wdata_w", 32'(mem_wdata), 32'h00AA);
    chk("t4_addr_w",  32'(mem_addr), 32'h0020);
    chk("t4_stall_w", 32'(mem_stall), 1);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("t4_stall_done", 32'(mem_stall), 0);
    chk("t4_wdata_done", 32'(mem_wdata), 32'h00AA);
    tick();
    chk("t4_valid", 32'(mw_valid), 1);
    chk("t4_rw",    32'(mw_reg_write), 0);
    chk("t4_mr",    32'(mw_mem_read), 0);

    // back-to-back load in the IDLE cycle after completion; read+write -> read
    drive(1, 1, 1, 1, 4'd9, 16'h0044, 16'h0077);
    mem_ready = 1'b1; mem_rdata = 16'h1111;
    #1;
    chk("b2b_req",   32'(mem_req), 1);
    chk("b2b_we",    32'(mem_we), 0);
    chk("b2b_stall", 32'(mem_stall), 0);
    tick();
    chk("b2b_data",  32'(mw_wb_data), 32'h1111);
    chk("b2b_rd",    32'(mw_reg_rd), 9);

    // 5: reset mid-WAIT
    drive(1, 1, 1, 0, 4'd6, 16'h0200, 16'h0000);
    mem_ready = 1'b0;
    tick();
    #1;
    chk("t5_pre_stall", 32'(mem_stall), 1);
    rst = 1'b1;
    #1;
    chk("t5_req",   32'(mem_req), 0);
    chk("t5_stall", 32'(mem_stall), 0);
    chk("t5_valid", 32'(mw_valid), 0);
    chk("t5_rd",    32'(mw_reg_rd), 0);
    chk("t5_data",  32'(mw_wb_data), 0);
    drive(0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    drive(1, 1, 1, 0, 4'd4, 16'h0300, 16'h0000);
    #1;
    chk("t5_idle_addr", 32'(mem_addr), 32'h0300);
    chk("t5_idle_req",  32'(mem_req), 1);
    mem_ready = 1'b1; mem_rdata = 16'h3333;
    tick();
    chk("t5_after_data", 32'(mw_wb_data), 32'h3333);

    // rd=0 passes through unmodified
    drive(1, 1, 0, 0, 4'd0, 16'h0ABC, 16'h0000);
    mem_ready = 1'b0;
    tick();
    chk("rd0_rd", 32'(mw_reg_rd), 0);
    chk("rd0_rw", 32'(mw_reg_write), 1);

    // 6: memory never ready
    drive(1, 1, 1, 0, 4'd2, 16'h0400, 16'h0000);
    mem_ready = 1'b0;
    #1;
    chk("t6_stall0", 32'(mem_stall), 1);
    tick();
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      chk("t6_stall", 32'(mem_stall), 1);
      chk("t6_err0",  32'(mem_err), 0);
      tick();
    end
    chk("t6_abort_req",   32'(mem_req), 0);
    chk("t6_abort_stall", 32'(mem_stall), 0);
    tick();
    chk("t6_err",   32'(mem_err), 1);
    chk("t6_valid", 32'(mw_valid), 1);
    chk("t6_rw",    32'(mw_reg_write), 0);
    chk("t6_mr",    32'(mw_mem_read), 0);
    chk("t6_rd",    32'(mw_reg_rd), 2);
    drive(0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000);
    tick();
    chk("t6_idle_stall", 32'(mem_stall), 0);
    chk("t6_err_sticky", 32'(mem_err), 1);
`else
    for (int i = 0; i < 12; i++) begin
      chk("t6_stall", 32'(mem_stall), 1);
      chk("t6_err0",  32'(mem_err), 0);
      tick();
    end
    mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick();
    chk("t6_data", 32'(mw_wb_data), 32'h7777);
    chk("t6_rw",   32'(mw_reg_write), 1);
    drive(0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000);
    mem_ready = 1'b0;
    tick();
    chk("t6_idle_stall", 32'(mem_stall), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
